// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU controller: RV32I ALU-op decode plus an optional iterative RV32M multiply/divide.
// Define ALU_MULDIV_EN to build the M-extension; otherwise M-ops decode as illegal.
module alu_ctrl_muldiv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ALUOp,
  input  logic                  RType,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [3:0]            Operation,
  output logic                  md_stall,
  output logic                  md_valid,
  output logic [DATA_WIDTH-1:0] md_result,
  output logic                  illegal_op
);

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  logic m_op;
  logic f7_bad;
  assign m_op   = (ALUOp == 2'b10) && RType && (Funct7 == F7Mul);
  // I-type carries immediate bits in Funct7, so only R-type needs an exact match.
  assign f7_bad = RType && (Funct7 != F7Base);

  always_comb begin
    Operation  = 4'b0010;
    illegal_op = 1'b0;
    case (ALUOp)
      2'b01: Operation = 4'b1000;
      2'b10: begin
        if (m_op) begin
`ifdef ALU_MULDIV_EN
          Operation = 4'b0010;
`else
          illegal_op = 1'b1;
`endif
        end else begin
          unique case (Funct3)
            3'b000: begin
              if (RType && (Funct7 == F7Alt)) Operation = 4'b0011;
              else illegal_op = f7_bad;
            end
            3'b001: begin
              Operation  = 4'b0100;
              illegal_op = (Funct7 != F7Base);
            end
            3'b010: begin
              Operation  = 4'b1100;
              illegal_op = f7_bad;
            end
            3'b101: begin
              Operation  = (Funct7 == F7Alt) ? 4'b0111 : 4'b0101;
              illegal_op = (Funct7 != F7Base) && (Funct7 != F7Alt);
            end
            3'b110: begin
              Operation  = 4'b0001;
              illegal_op = f7_bad;
            end
            3'b111: begin
              Operation  = 4'b0000;
              illegal_op = f7_bad;
            end
            default: illegal_op = 1'b1;
          endcase
        end
      end
      default: Operation = 4'b0010;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2*W-1:0]       prod_q, step_prod, mul_full;
  logic [W-1:0]         opb_q, md_result_q, a_mag, b_mag;
  logic [W-1:0]         quo_fix, rem_fix, fin_res, spec_res;
  logic [W:0]           add_sum, rem_shift, rem_diff;
  logic [2:0]           f3_q;
  logic                 neg_q, neg_rem_q, md_valid_q;
  logic                 sgn_a, sgn_b, div_zero, div_ovf;

  // Accept-cycle operand conditioning and the two results that skip iteration.
  always_comb begin
    sgn_a    = src_a[W-1] && (Funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    sgn_b    = src_b[W-1] && (Funct3 inside {3'b001, 3'b100, 3'b110});
    a_mag    = sgn_a ? (~src_a + 1'b1) : src_a;
    b_mag    = sgn_b ? (~src_b + 1'b1) : src_b;
    div_zero = Funct3[2] && (src_b == '0);
    div_ovf  = Funct3[2] && !Funct3[0] && (src_a == MinVal) && (src_b == '1);
    if (div_zero) spec_res = Funct3[1] ? src_a : '1;
    else          spec_res = Funct3[1] ? '0 : MinVal;
  end

  // prod_q holds {acc, multiplier} for MUL* and {remainder, quotient} for DIV*/REM*.
  always_comb begin
    add_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    rem_shift = {prod_q[2*W-1:W], prod_q[W-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    if (!f3_q[2])        step_prod = {add_sum, prod_q[W-1:1]};
    else if (!rem_diff[W]) step_prod = {rem_diff[W-1:0], prod_q[W-2:0], 1'b1};
    else                 step_prod = {rem_shift[W-1:0], prod_q[W-2:0], 1'b0};

    mul_full = neg_q ? (~step_prod + 1'b1) : step_prod;
    quo_fix  = neg_q ? (~step_prod[W-1:0] + 1'b1) : step_prod[W-1:0];
    rem_fix  = neg_rem_q ? (~step_prod[2*W-1:W] + 1'b1) : step_prod[2*W-1:W];
    if (f3_q[2])                fin_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q[1:0] == 2'b00) fin_res = mul_full[W-1:0];
    else                        fin_res = mul_full[2*W-1:W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prod_q      <= '0;
      opb_q       <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      md_valid_q  <= 1'b0;
      md_result_q <= '0;
    end else if (flush) begin
      state_q    <= StIdle;
      md_valid_q <= 1'b0;
    end else begin
      md_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && m_op) begin
            f3_q      <= Funct3;
            neg_q     <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;
            cnt_q     <= '0;
            opb_q     <= Funct3[2] ? b_mag : a_mag;
            prod_q    <= {{W{1'b0}}, (Funct3[2] ? a_mag : b_mag)};
            if (div_zero || div_ovf) begin
              md_result_q <= spec_res;
              md_valid_q  <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(W - 1)) begin
            md_result_q <= fin_res;
            md_valid_q  <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign md_stall  = in_valid && m_op && (state_q != StDone) && !flush;
  assign md_valid  = md_valid_q;
  assign md_result = md_result_q;
`else
  logic md_unused;
  assign md_unused = ^{clk, reset, in_valid, flush, src_a, src_b};
  assign md_stall  = 1'b0;
  assign md_valid  = 1'b0;
  assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: decode table, M-op scoreboard, flush/reset sequences.
module tb_alu_ctrl_muldiv;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic         RType;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic         in_valid;
  logic         flush;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [3:0]   Operation;
  logic         md_stall;
  logic         md_valid;
  logic [W-1:0] md_result;
  logic         illegal_op;

  alu_ctrl_muldiv #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOp     (ALUOp),
    .RType     (RType),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .in_valid  (in_valid),
    .flush     (flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .Operation (Operation),
    .md_stall  (md_stall),
    .md_valid  (md_valid),
    .md_result (md_result),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  typedef struct {
    logic [1:0] aluop;
    logic       rtype;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       chk_op;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           stall;
  } mop_vec_t;

  dec_vec_t dec_tab[16];
  mop_vec_t mop_tab[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every md_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && md_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL md_valid_unexpected actual=%0h required=none", md_result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("md_result", {32'h0, md_result}, {32'h0, mon_exp});
      end
    end
  end

  // Issue one M-op, count stall cycles (scrambling sources after accept), check the pulse.
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input int stall);
    int  n;
    bit  done;
    ALUOp    = 2'b10;
    RType    = 1'b1;
    Funct7   = 7'b0000001;
    Funct3   = f3;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    exp_q.push_back(res);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (md_stall) begin
        n++;
        @(negedge clk);
        src_a = $urandom;
        src_b = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    check({name, "_stall"}, 64'(n), 64'(stall));
    check({name, "_valid"}, {63'h0, md_valid}, 64'h1);
    @(negedge clk);
    #1;
    check({name, "_pulse"}, {63'h0, md_valid}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ALUOp = 2'b00; RType = 1'b0; Funct7 = '0; Funct3 = '0;
    in_valid = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;

    dec_tab[0]  = '{2'b10, 1'b1, 7'h20, 3'b000, 4'b0011, 1'b1, 1'b0};
    dec_tab[1]  = '{2'b10, 1'b0, 7'h20, 3'b000, 4'b0010, 1'b1, 1'b0};
    dec_tab[2]  = '{2'b10, 1'b1, 7'h00, 3'b000, 4'b0010, 1'b1, 1'b0};
    dec_tab[3]  = '{2'b10, 1'b1, 7'h00, 3'b111, 4'b0000, 1'b1, 1'b0};
    dec_tab[4]  = '{2'b10, 1'b1, 7'h00, 3'b110, 4'b0001, 1'b1, 1'b0};
    dec_tab[5]  = '{2'b10, 1'b1, 7'h00, 3'b001, 4'b0100, 1'b1, 1'b0};
    dec_tab[6]  = '{2'b10, 1'b1, 7'h00, 3'b101, 4'b0101, 1'b1, 1'b0};
    dec_tab[7]  = '{2'b10, 1'b1, 7'h20, 3'b101, 4'b0111, 1'b1, 1'b0};
    dec_tab[8]  = '{2'b10, 1'b1, 7'h00, 3'b010, 4'b1100, 1'b1, 1'b0};
    dec_tab[9]  = '{2'b10, 1'b0, 7'h20, 3'b101, 4'b0111, 1'b1, 1'b0};
    dec_tab[10] = '{2'b10, 1'b0, 7'h7f, 3'b110, 4'b0001, 1'b1, 1'b0};
    dec_tab[11] = '{2'b00, 1'b1, 7'h00, 3'b000, 4'b0010, 1'b1, 1'b0};
    dec_tab[12] = '{2'b01, 1'b1, 7'h00, 3'b000, 4'b1000, 1'b1, 1'b0};
    dec_tab[13] = '{2'b11, 1'b0, 7'h00, 3'b000, 4'b0010, 1'b1, 1'b0};
    dec_tab[14] = '{2'b10, 1'b1, 7'h00, 3'b100, 4'b0000, 1'b0, 1'b1};
    dec_tab[15] = '{2'b10, 1'b1, 7'h20, 3'b110, 4'b0000, 1'b0, 1'b1};

    mop_tab[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    mop_tab[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    mop_tab[2]  = '{3'b001, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33};
    mop_tab[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    mop_tab[4]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    mop_tab[5]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    mop_tab[6]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    mop_tab[7]  = '{3'b101, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1};
    mop_tab[8]  = '{3'b111, 32'h00000009, 32'h00000000, 32'h00000009, 1};
    mop_tab[9]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    mop_tab[10] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    mop_tab[11] = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 33};
    mop_tab[12] = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 33};
    mop_tab[13] = '{3'b100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1};
    mop_tab[14] = '{3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1};
    mop_tab[15] = '{3'b100, 32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA, 33};

    #12;
    check("rst_md_valid", {63'h0, md_valid}, 64'h0);
    check("rst_md_result", {32'h0, md_result}, 64'h0);
    check("rst_md_stall", {63'h0, md_stall}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ALUOp = dec_tab[i].aluop; RType = dec_tab[i].rtype;
      Funct7 = dec_tab[i].f7; Funct3 = dec_tab[i].f3; in_valid = 1'b1;
      #1;
      if (dec_tab[i].chk_op)
        check($sformatf("dec%0d_op", i), {60'h0, Operation}, {60'h0, dec_tab[i].op});
      check($sformatf("dec%0d_ill", i), {63'h0, illegal_op}, {63'h0, dec_tab[i].ill});
      check($sformatf("dec%0d_stall", i), {63'h0, md_stall}, 64'h0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;

`ifdef ALU_MULDIV_EN
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b000;
    #1;
    check("mop_ill", {63'h0, illegal_op}, 64'h0);
    check("mop_op", {60'h0, Operation}, 64'h2);

    for (int i = 0; i < 16; i++)
      run_mop($sformatf("mop%0d", i), mop_tab[i].f3, mop_tab[i].a, mop_tab[i].b,
              mop_tab[i].res, mop_tab[i].stall);
    in_valid = 1'b0;

    // Flush in the 10th CALC cycle: no pulse, result held, FSM back in IDLE.
    @(negedge clk);
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b000;
    src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", {63'h0, md_stall}, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", {63'h0, md_valid}, 64'h0);
    check("flush_result", {32'h0, md_result}, {32'h0, mop_tab[15].res});
    run_mop("post_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);
    in_valid = 1'b0;

    // Reset in CALC cycle 5.
    @(negedge clk);
    Funct3 = 3'b101; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_result", {32'h0, md_result}, 64'h0);
    check("rst_mid_valid", {63'h0, md_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_mop("post_reset", 3'b101, 32'd1000, 32'd3, 32'd333, 33);
    in_valid = 1'b0;
`else
    begin
      logic seen;
      seen = 1'b0;
      for (int f = 0; f < 8; f++) begin
        ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = f[2:0];
        src_a = 32'd7; src_b = 32'hFFFFFFFD; in_valid = 1'b1;
        #1;
        check($sformatf("nomd%0d_ill", f), {63'h0, illegal_op}, 64'h1);
        check($sformatf("nomd%0d_op", f), {60'h0, Operation}, 64'h2);
        check($sformatf("nomd%0d_stall", f), {63'h0, md_stall}, 64'h0);
        @(negedge clk);
      end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        seen = seen | md_valid;
      end
      in_valid = 1'b0;
      check("nomd_valid_seen", {63'h0, seen}, 64'h0);
      check("nomd_result", {32'h0, md_result}, 64'h0);
    end
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
